// File: rtl/biquad_coef_bank.sv
// Wishbone coefficient bank for a biquad cascade: double-buffered shadow/active
// coefficient registers with sample-synchronous commit, plus x/y sample capture.
module biquad_coef_bank #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NSECT     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cyc_i,
  input  logic                           stb_i,
  input  logic                           we_i,
  input  logic [31:0]                    adr_i,
  input  logic [31:0]                    dat_i,
  output logic [31:0]                    dat_o,
  output logic                           ack_o,
  input  logic                           sample_stb_i,
  input  logic [DATAWIDTH-1:0]           x_i,
  input  logic [DATAWIDTH-1:0]           y_i,
  output logic [NSECT*5*DATAWIDTH-1:0]   coef_o,
  output logic                           coef_upd_o,
  output logic                           pending_o
);

  localparam int unsigned CW = NSECT * 5 * DATAWIDTH;

  logic [CW-1:0]        shadow_q, shadow_d;
  logic [CW-1:0]        active_q, active_d;
  logic [DATAWIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 ack_q, ack_d;
  logic                 upd_q, upd_d;
  logic [31:0]          dat_q, dat_d;

  logic        hit, accept, coef_hit, coef_wr, ctrl_wr, commit_req, revert, xfer;
  logic [7:0]  word;
  logic [3:0]  sect;
  logic [2:0]  kidx;
  int unsigned cidx;
  logic [31:0] rdata;

  function automatic logic [15:0] left_align(input logic [DATAWIDTH-1:0] v);
    logic [15:0] t;
    t = '0;
    t[15 -: DATAWIDTH] = v;
    return t;
  endfunction

  always_comb begin
    hit        = cyc_i & stb_i & (adr_i[31:10] == BASE_ADDR[31:10]);
    accept     = hit & ~ack_q;
    word       = adr_i[9:2];
    sect       = word[6:3];
    kidx       = word[2:0];
    coef_hit   = ~word[7] & (32'(sect) < NSECT) & (kidx < 3'd5);
    cidx       = 32'(sect) * 5 + 32'(kidx);
    coef_wr    = accept & we_i & coef_hit;
    ctrl_wr    = accept & we_i & (word == 8'h80);
    revert     = ctrl_wr & dat_i[1];
    commit_req = ctrl_wr & dat_i[0];
    // A revert on the strobe edge cancels the pending transfer outright.
    xfer       = sample_stb_i & pend_q & ~revert;

    rdata = '0;
    if (coef_hit) begin
      rdata[15:0] = left_align(shadow_q[cidx*DATAWIDTH +: DATAWIDTH]);
    end else begin
      case (word)
        8'h81:   rdata = {16'h0000, cnt_q, 7'b0, pend_q};
        8'h82:   rdata[15:0] = left_align(x_q);
        8'h83:   rdata[15:0] = left_align(y_q);
        default: rdata = '0;
      endcase
    end

    shadow_d = shadow_q;
    active_d = active_q;
    if (xfer) active_d = shadow_q;
    if (revert) begin
      shadow_d = active_q;
    end else if (coef_wr) begin
      shadow_d[cidx*DATAWIDTH +: DATAWIDTH] = dat_i[15 -: DATAWIDTH];
    end

    // Priority: revert clears, a commit (re)arms, otherwise a transfer consumes.
    if (revert)          pend_d = 1'b0;
    else if (commit_req) pend_d = 1'b1;
    else if (xfer)       pend_d = 1'b0;
    else                 pend_d = pend_q;

    cnt_d = cnt_q + {7'b0, xfer};
    x_d   = sample_stb_i ? x_i : x_q;
    y_d   = sample_stb_i ? y_i : y_q;
    ack_d = accept;
    dat_d = accept ? rdata : dat_q;
    upd_d = xfer;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      upd_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      upd_q    <= upd_d;
      dat_q    <= dat_d;
    end
  end

  assign dat_o      = dat_q;
  assign ack_o      = ack_q;
  assign coef_o     = active_q;
  assign coef_upd_o = upd_q;
  assign pending_o  = pend_q;

endmodule

// File: tb/tb_biquad_coef_bank.sv
// Scoreboard bench for biquad_coef_bank: a 16-bit/4-section bank and a
// 12-bit/2-section bank share one Wishbone bus at different base addresses.
module tb_biquad_coef_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic        sstb = 1'b0;
  logic [15:0] xs = '0, ys = '0;

  logic [31:0]  dat0, dat1;
  logic         ack0, ack1, upd0, upd1, pend0, pend1;
  logic [319:0] coef0;
  logic [119:0] coef1;

  int n_chk  = 0;
  int n_fail = 0;
  int last_lat;

  logic [32:0] sb_q[$];
  string       sb_n[$];

  always #5 clk = ~clk;

  biquad_coef_bank #(.DATAWIDTH(16), .NSECT(4), .BASE_ADDR(32'h3000_0000)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat0), .ack_o(ack0), .sample_stb_i(sstb), .x_i(xs), .y_i(ys),
    .coef_o(coef0), .coef_upd_o(upd0), .pending_o(pend0));

  biquad_coef_bank #(.DATAWIDTH(12), .NSECT(2), .BASE_ADDR(32'h4000_0000)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat1), .ack_o(ack1), .sample_stb_i(sstb), .x_i(xs[15:4]),
    .y_i(ys[15:4]), .coef_o(coef1), .coef_upd_o(upd1), .pending_o(pend1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int unsigned i);
    return {16'h0000, coef0[i*16 +: 16]};
  endfunction

  // Monitor: every ack pops one scoreboard entry; reads are compared.
  always @(negedge clk) begin
    logic [32:0] e;
    string       nm;
    if (ack0 | ack1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard expected no ack");
      end else begin
        e  = sb_q.pop_front();
        nm = sb_n.pop_front();
        if (e[32]) begin
          n_chk++;
          if ((ack0 ? dat0 : dat1) !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, ack0 ? dat0 : dat1, e[31:0]);
          end
        end
      end
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input logic with_stb, input logic exp_ack,
                     input string nm);
    int   lat;
    logic got;
    @(negedge clk);
    if (exp_ack) begin
      sb_q.push_back({~w, exp});
      sb_n.push_back(nm);
    end
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sstb = with_stb;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      sstb = 1'b0;
      if (ack0 | ack1) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    last_lat = lat;
    if (got !== exp_ack) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ack: got %0d expected %0d", nm, got, exp_ack);
      if (exp_ack) begin
        void'(sb_q.pop_back());
        void'(sb_n.pop_back());
      end
    end else if (!exp_ack) begin
      n_chk++;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic s);
    bus(1'b1, a, d, '0, s, 1'b1, "wr");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic s, input string nm);
    bus(1'b0, a, '0, exp, s, 1'b1, nm);
  endtask

  task automatic pulse;
    @(negedge clk);
    sstb = 1'b1;
    @(negedge clk);
    sstb = 1'b0;
  endtask

  localparam logic [31:0] B = 32'h3000_0000;

  initial begin
    logic [319:0] snap;
    logic         bad;

    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, ack0}, 0);
    check("rst_dat", dat0, 0);
    check("rst_coef", {31'b0, |coef0}, 0);
    check("rst_pend", {31'b0, pend0}, 0);
    check("rst_upd", {31'b0, upd0}, 0);
    rst = 1'b0;

    rd(B + 32'h000, 32'h0, 1'b0, "rd_off0");
    check("latency", last_lat, 1);
    rd(B + 32'h204, 32'h0, 1'b0, "rd_status0");

    // Basic write, commit and transfer
    wr(B + 32'h028, 32'hABCD_4001, 1'b0);
    rd(B + 32'h028, 32'h0000_4001, 1'b0, "rd_s1b10");
    check("coef_pre_commit", fld(7), 0);
    wr(B + 32'h200, 32'h1, 1'b0);
    check("pend_set", {31'b0, pend0}, 1);
    pulse();
    check("coef_s1b10", fld(7), 32'h4001);
    check("upd_pulse", {31'b0, upd0}, 1);
    check("pend_clr", {31'b0, pend0}, 0);
    @(negedge clk);
    check("upd_once", {31'b0, upd0}, 0);
    rd(B + 32'h204, 32'h0000_0100, 1'b0, "rd_status1");

    // Pending commit held with no strobe, then reverted
    wr(B + 32'h040, 32'h1234, 1'b0);
    wr(B + 32'h200, 32'h1, 1'b0);
    snap = coef0;
    bad  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pend0 !== 1'b1 || coef0 !== snap) bad = 1'b1;
    end
    check("hold_100", {31'b0, bad}, 0);
    wr(B + 32'h200, 32'h2, 1'b0);
    check("revert_pend", {31'b0, pend0}, 0);
    rd(B + 32'h040, 32'h0, 1'b0, "rd_reverted_s2a11");
    rd(B + 32'h028, 32'h4001, 1'b0, "rd_reverted_s1b10");

    // Shadow write on the transfer edge
    wr(B + 32'h000, 32'h1111, 1'b0);
    wr(B + 32'h200, 32'h1, 1'b0);
    wr(B + 32'h000, 32'h2222, 1'b1);
    check("sim_wr_active", fld(0), 32'h1111);
    check("sim_wr_pend", {31'b0, pend0}, 0);
    rd(B + 32'h000, 32'h2222, 1'b0, "sim_wr_shadow");
    rd(B + 32'h204, 32'h0000_0200, 1'b0, "sim_wr_status");

    // Commit write on the transfer edge re-arms
    wr(B + 32'h200, 32'h1, 1'b0);
    wr(B + 32'h004, 32'h3333, 1'b0);
    wr(B + 32'h200, 32'h1, 1'b1);
    check("rearm_f0", fld(0), 32'h2222);
    check("rearm_f1", fld(1), 32'h3333);
    check("rearm_pend", {31'b0, pend0}, 1);
    rd(B + 32'h204, 32'h0000_0301, 1'b0, "rearm_status");

    // Revert (with commit bit) on a strobe edge while pending
    wr(B + 32'h008, 32'h5555, 1'b0);
    wr(B + 32'h200, 32'h3, 1'b1);
    check("rev_stb_pend", {31'b0, pend0}, 0);
    check("rev_stb_f2", fld(2), 0);
    rd(B + 32'h008, 32'h0, 1'b0, "rev_stb_shadow");
    rd(B + 32'h204, 32'h0000_0300, 1'b0, "rev_stb_status");

    // Commit with nothing pending on a strobe edge: arms only
    wr(B + 32'h008, 32'h6666, 1'b0);
    wr(B + 32'h200, 32'h1, 1'b1);
    check("arm_stb_f2", fld(2), 0);
    check("arm_stb_pend", {31'b0, pend0}, 1);
    pulse();
    check("arm_then_f2", fld(2), 32'h6666);
    rd(B + 32'h204, 32'h0000_0400, 1'b0, "arm_then_status");

    // Sample capture and read-on-capture-edge
    xs = 16'hAAAA; ys = 16'h5555;
    pulse();
    xs = 16'h1357; ys = 16'h2468;
    rd(B + 32'h208, 32'h0000_AAAA, 1'b1, "rd_x_capture_edge");
    rd(B + 32'h208, 32'h0000_1357, 1'b0, "rd_x_new");
    rd(B + 32'h20C, 32'h0000_2468, 1'b0, "rd_y_new");

    // Commit count wrap
    for (int i = 0; i < 251; i++) begin
      wr(B + 32'h200, 32'h1, 1'b0);
      pulse();
    end
    rd(B + 32'h204, 32'h0000_FF00, 1'b0, "cnt_255");
    wr(B + 32'h200, 32'h1, 1'b0);
    pulse();
    rd(B + 32'h204, 32'h0000_0000, 1'b0, "cnt_wrap");

    // Unmapped and out-of-window accesses
    rd(B + 32'h3F0, 32'h0, 1'b0, "rd_unmapped");
    wr(B + 32'h3F0, 32'hFFFF_FFFF, 1'b0);
    rd(B + 32'h200, 32'h0, 1'b0, "rd_ctrl");
    rd(B + 32'h080, 32'h0, 1'b0, "rd_sect_oob");
    rd(B + 32'h014, 32'h0, 1'b0, "rd_k5");
    bus(1'b0, B + 32'h400, '0, '0, 1'b0, 1'b0, "rd_outside");

    // 12-bit bank
    wr(32'h4000_0000, 32'h0000_7FF8, 1'b0);
    rd(32'h4000_0000, 32'h0000_7FF0, 1'b0, "dw12_rd");
    wr(32'h4000_0200, 32'h1, 1'b0);
    pulse();
    check("dw12_coef", {20'h0, coef1[11:0]}, 32'h7FF);

    // Reset while ack is asserted
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 32'h028;
    @(posedge clk);
    #1;
    check("pre_rst_ack", {31'b0, ack0}, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'b0, ack0}, 0);
    check("rst_mid_dat", dat0, 0);
    check("rst_mid_coef", {31'b0, |coef0}, 0);
    check("rst_mid_coef1", {31'b0, |coef1}, 0);
    check("rst_mid_pend", {31'b0, pend0}, 0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(B + 32'h028, 32'h0, 1'b0, "post_rst_shadow");
    rd(B + 32'h204, 32'h0, 1'b0, "post_rst_status");
    rd(B + 32'h208, 32'h0, 1'b0, "post_rst_x");

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/biquad_coef_bank.md
Name: biquad_coef_bank

Overview:
- Wishbone slave holding coefficients for a cascade of NSECT biquad sections (a11, a12, b10, b11, b12 per section).
- Double-buffered: bus writes land in a shadow bank. A software commit request is applied to the active bank on the next filter sample strobe, so coefficients change atomically between samples.
- Captures the filter input/output samples on each sample strobe for bus readback.
- Sits between the Wishbone interconnect and the biquad cascade datapath.

Parameters:
- DATAWIDTH, 16, coefficient/sample width (1..16); a coefficient is the DATAWIDTH MSBs of dat_i[15:0].
- NSECT, 4, number of biquad sections (1..16).
- BASE_ADDR, 32'h3000_0000, slave base byte address; must be 1 KiB aligned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  32  byte address
- dat_i  in  32  write data
- dat_o  out  32  read data, registered
- ack_o  out  1  acknowledge, registered
- sample_stb_i  in  1  one-cycle pulse per filter sample
- x_i  in  DATAWIDTH  filter input sample
- y_i  in  DATAWIDTH  filter output sample
- coef_o  out  NSECT*5*DATAWIDTH  active coefficients; section s, coef k at [(5s+k)*DATAWIDTH +: DATAWIDTH]; k = 0 a11, 1 a12, 2 b10, 3 b11, 4 b12
- coef_upd_o  out  1  one-cycle pulse the cycle after the active bank is updated
- pending_o  out  1  commit pending

Behaviour:
- Reset (async): shadow, active, x/y captures, commit count, pending, ack_o, dat_o and coef_upd_o all 0.
- Hit condition: cyc_i & stb_i & (adr_i[31:10] == BASE_ADDR[31:10]). On a non-hit, ack_o stays 0.
- Accept: accept = hit & ~ack_o. On the accept edge:
  - any write takes effect;
  - ack_o <= 1 and dat_o <= read data;
  - next cycle ack_o <= 0.
  - Result: 1 wait state; back-to-back accesses complete every 2 cycles.
- Address map (offset = adr_i[9:0], word aligned; adr_i[1:0] ignored):
  - 0x20*s + 4*k, s < NSECT, k 0..4: shadow coefficient. Read returns the **shadow** value, left-aligned in [15:0], zero elsewhere.
  - 0x200 CTRL, write-only (reads 0):
    - bit0 = commit request, sets pending.
    - bit1 = revert: shadow <= active, pending <= 0. Revert wins over bit0.
  - 0x204 STATUS, read-only: bit0 = pending; [15:8] = commit count mod 256.
  - 0x208 X: last captured x_i, left-aligned in [15:0].
  - 0x20C Y: last captured y_i, left-aligned in [15:0].
  - Any other offset inside the 1 KiB window: acked; read 0; write ignored.
- Write granularity: whole 32-bit word; dat_i[31:16] ignored.
- Transfer: on an edge with sample_stb_i & pending:
  - active <= shadow (all sections);
  - pending <= 0;
  - count++ (wraps 255 -> 0);
  - coef_upd_o = 1 on the following cycle.
- Sample capture: x/y captures load on every sample_stb_i, regardless of pending.
- Simultaneous events on the same edge:
  - Shadow write + transfer: active takes the old shadow value; shadow takes the new value.
  - Commit write + transfer with pending = 1: transfer occurs and pending stays 1 (re-armed).
  - Commit write with pending = 0 + sample_stb_i: pending -> 1, no transfer this edge.
  - Revert + sample_stb_i with pending = 1: revert wins; no transfer; pending = 0.
  - Read of X/Y on the capture edge returns the pre-capture value.
- coef_o is driven directly from the active registers; there is no combinational path from the bus.
- Reset mid-transaction: ack_o clears immediately; the master must re-issue the access.

Test Plan:
- Reset, then read offset 0x000 and STATUS -> ack after 1 wait state; data 0; coef_o = 0; pending_o = 0.
- Write 0x4001 to section 1 b10 (offset 0x28) and read it back -> 0x0000_4001; coef_o unchanged; then CTRL = 1 and pulse sample_stb_i -> coef_o field (5+2) = 0x4001, coef_upd_o pulses once, STATUS = 0x0100.
- Commit without a sample strobe for 100 cycles -> pending_o = 1 and coef_o unchanged throughout; then CTRL = 2 -> pending 0; shadow reads equal active values.
- Shadow write, commit write and sample_stb_i arranged on the same edges per the simultaneous-event rules -> active, shadow and pending exactly as specified; 256 commits -> count wraps to 0.
- Access to an unmapped offset 0x3F0 -> ack with data 0; access to BASE_ADDR + 0x400 -> no ack.
- DATAWIDTH = 12 build: write 0x7FF8 -> coef = 0x7FF and readback 0x7FF0. Assert rst_i during ack -> ack_o and all registers 0 asynchronously.
